multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Control unit for the multicycle ARM-subset CPU, replacing single-cycle decode.
- A Moore main FSM sequences the shared datapath (one memory, one ALU, instruction/data registers) through fetch, decode, execute, memory and writeback.
- It also contains the ALU decoder and conditional-execution logic (NZCV flags register and condition check).
- It sits inside CPU alongside the datapath. It drives every datapath enable and mux select.

Parameters:
PC_REG, 15, register index treated as PC; a writeback to it is a PC write.
RESET_STATE, 0, encoding of FETCH loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
cond  in  4  Instr[31:28]
op  in  2  Instr[27:26]
funct  in  6  Instr[25:20] (I, cmd[3:0], S/L)
rd  in  4  Instr[15:12]
alu_flags  in  4  NZCV from ALU, current cycle
pc_write  out  1  PC register enable
mem_write  out  1  memory write enable
reg_write  out  1  register-file write enable
ir_write  out  1  instruction register enable
adr_src  out  1  0=PC, 1=ALUOut as memory address
alu_src_a  out  1  0=Rn, 1=PC
alu_src_b  out  2  00=Rm, 01=ExtImm, 10=const 4
result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
imm_src  out  2  op (00 imm8, 01 imm12, 10 imm24)
reg_src  out  2  [0]=op==10 (Rn:=15), [1]=op==01 (Rm:=Rd)
alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV(pass B)
state_dbg  out  4  current FSM state

Behaviour:
- Reset: on a rising clk edge with rst==0: state<=FETCH, flags<=0000, condex_q<=0. While rst==0, pc_write, mem_write, reg_write and ir_write are forced 0; the other outputs are don't-care. Reset takes effect from any state, discarding the instruction in flight.
- States and Moore outputs (unlisted signals are 0/00):
  - FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, ir_write=1, next_pc=1.
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
  - MEMADR: alu_src_b=01.
  - MEMRD: adr_src=1.
  - MEMWB: result_src=01, regw=1.
  - MEMWR: adr_src=1, memw=1.
  - EXECR: alu_src_b=00, aluop=1.
  - EXECI: alu_src_b=01, aluop=1.
  - ALUWB: regw=1.
  - BRANCH: alu_src_b=01, result_src=10, branch=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op==01 -> MEMADR; op==00 & funct[5]==0 -> EXECR; op==00 & funct[5]==1 -> EXECI; op==10 -> BRANCH; op==11 -> FETCH (no-op).
  - MEMADR -> MEMRD if funct[0]==1, else MEMWR.
  - MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3.
- ALU decode, active only when aluop=1. cmd=funct[4:1]:
  - 0100 -> ADD; 0010 -> SUB; 0000 -> AND; 1100 -> ORR; 1101 -> MOV; 1010 -> CMP (SUB, no_write=1).
  - Any other cmd -> ADD with no_write=1.
  - When aluop=0, alu_control=ADD.
- Flag enables:
  - flag_w[1] (NZ) = aluop & funct[0].
  - flag_w[0] (CV) = aluop & funct[0] & cmd∈{ADD,SUB,CMP}.
- Condition check: condex from the flags register per ARM codes EQ..AL (0000..1110); 1111 -> 0. condex_q is latched at the end of DECODE and used by every later state of that instruction.
- Flags register: updated at the end of EXECR/EXECI, per enabled half, when condex_q==1. The updated flags affect the next instruction only.
- Gated outputs:
  - reg_write = regw & condex_q & ~no_write_q. no_write_q is latched in EXECR/EXECI.
  - mem_write = memw & condex_q.
  - pcs = branch | (regw & rd==PC_REG).
  - pc_write = next_pc | (pcs & condex_q).
- A failed condition still walks the full state path, with no architectural writes except the FETCH PC+4.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state_t enum (FETCH..BRANCH, 4-bit);
  - ALU control constants (ALU_ADD..ALU_MOV);
  - cmd codes (CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_MOV, CMD_CMP);
  - cond codes (COND_EQ..COND_AL);
  - result_src and alu_src_b select constants.
- Sub-module cond_unit holds the flags register, condition evaluation, condex_q and the flag-write gating. multicycle_ctrl contains the FSM, ALU decoder and output gating.

Test Plan:
- Reset then E3A02007 (MOV R2,#7) -> states FETCH,DECODE,EXECI,ALUWB. alu_control=100, alu_src_b=01, reg_write=1 only in ALUWB, pc_write=1 only in FETCH.
- E0825003 (ADD R5,R2,R3) -> EXECR with alu_src_b=00, alu_control=000; flags unchanged (S=0). Then E2488004 (SUB R8,R8,#4) -> alu_control=001.
- E5813A01 (STR) -> FETCH,DECODE,MEMADR,MEMWR; mem_write=1 with adr_src=1 in MEMWR. E591AA01 (LDR) -> MEMADR,MEMRD,MEMWB; reg_write=1 with result_src=01.
- EAFFFFFE (B) -> FETCH,DECODE,BRANCH; pc_write=1 in BRANCH, result_src=10, reg_src[0]=1.
- E3520000 (CMP R2,#0) with alu_flags=0100 -> reg_write=0 throughout, flags=0100. Then 0A000002 (BEQ) -> pc_write=1 in BRANCH. With alu_flags=0000 on the CMP instead, BEQ gives pc_write=0 in BRANCH.
- rst=0 asserted during MEMRD -> next cycle state=FETCH, flags=0000, all write enables 0 while rst low; no reg_write from the aborted LDR.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and encodings for the multicycle ARM-subset control unit
// Holds the FSM state type, ALU control codes, data-processing cmd codes,
// condition codes and the datapath mux select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/cond_unit.sv
// cond_unit: NZCV flags register, ARM condition evaluation and latched condex
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   cond[3:0]         instruction condition field
//   alu_flags[3:0]    NZCV from the ALU this cycle
//   flag_w[1:0]       [1]=update NZ, [0]=update CV (already qualified by aluop/S)
//   latch_condex      high in DECODE; captures the condition result for the instruction
//   condex_q          condition result held for the rest of the instruction
module cond_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       latch_condex,
    output logic       condex_q
);

    logic [3:0] flags_q, flags_d;
    logic       condex_d, condex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = n ~^ v;
            COND_LT: condex = n ^ v;
            COND_GT: condex = ~z & (n ~^ v);
            COND_LE: condex = z | (n ^ v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
        // A failed condition must leave the flags untouched.
        flags_d = flags_q;
        if (flag_w[1] & condex_q) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0] & condex_q) flags_d[1:0] = alu_flags[1:0];
        condex_d = latch_condex ? condex : condex_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore main FSM, ALU decoder and write gating for the multicycle ARM-subset CPU
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cond, op, funct, rd      instruction fields from the instruction register
//   alu_flags                NZCV from the ALU this cycle
//   pc_write, mem_write,
//   reg_write, ir_write      datapath write enables (forced low while rst==0)
//   adr_src, alu_src_a,
//   alu_src_b, result_src    datapath mux selects driven by the FSM state
//   imm_src, reg_src         extender / register-address selects decoded from op
//   alu_control              ALU operation
//   state_dbg                current FSM state
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_REG      = 15,
    parameter int RESET_STATE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [2:0] alu_control,
    output logic [3:0] state_dbg
);

    state_t     state_q, state_d;
    logic       no_write_q, no_write_d, no_write;
    logic       next_pc, regw, memw, branch, aluop, irw, pcs, condex_q;
    logic [1:0] flag_w;
    logic [3:0] cmd;

    assign cmd = funct[4:1];

    always_comb begin
        state_d    = state_q;
        next_pc    = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        aluop      = 1'b0;
        irw        = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RM;
        result_src = RES_ALUOUT;
        case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                irw        = 1'b1;
                next_pc    = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_d    = op == 2'b01 ? MEMADR :
                             op == 2'b10 ? BRANCH :
                             op == 2'b11 ? FETCH  :
                             funct[5]    ? EXECI  : EXECR;
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                regw       = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                adr_src = 1'b1;
                memw    = 1'b1;
                state_d = FETCH;
            end
            EXECR: begin
                aluop   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                alu_src_b = SRCB_IMM;
                aluop     = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regw    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        no_write    = 1'b0;
        if (aluop) begin
            case (cmd)
                CMD_ADD: alu_control = ALU_ADD;
                CMD_SUB: alu_control = ALU_SUB;
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_MOV: alu_control = ALU_MOV;
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    no_write    = 1'b1;
                end
                default: no_write = 1'b1;
            endcase
        end
        flag_w[1] = aluop & funct[0];
        flag_w[0] = aluop & funct[0] & (cmd == CMD_ADD | cmd == CMD_SUB | cmd == CMD_CMP);
        // Cleared in DECODE so a CMP's suppression never leaks into a later LDR writeback.
        no_write_d = aluop ? no_write : (state_q == DECODE) ? 1'b0 : no_write_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= state_t'(4'(RESET_STATE));
            no_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            no_write_q <= no_write_d;
        end
    end

    cond_unit u_cond (
        .clk          (clk),
        .rst          (rst),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_w       (flag_w),
        .latch_condex (state_q == DECODE),
        .condex_q     (condex_q)
    );

    assign pcs       = branch | (regw & (rd == 4'(PC_REG)));
    assign reg_write = rst & regw & condex_q & ~no_write_q;
    assign mem_write = rst & memw & condex_q;
    assign pc_write  = rst & (next_pc | (pcs & condex_q));
    assign ir_write  = rst & irw;
    assign imm_src   = op;
    assign reg_src   = {op == 2'b01, op == 2'b10};
    assign state_dbg = state_q;

endmodule
